// File: rtl/sram_init_loader_pkg.sv
// Shared definitions for the SRAM init loader: target codes, FSM states,
// header field positions and the per-target bank legality rule.
package sram_init_loader_pkg;

  typedef enum logic [2:0] {
    TGT_FV      = 3'd0,
    TGT_FV_INFO = 3'd1,
    TGT_NB_INFO = 3'd2,
    TGT_IMEM    = 3'd3,
    TGT_NB      = 3'd4,
    TGT_END     = 3'd7
  } tgt_e;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Header word layout (LSB positions)
  localparam int HDR_TGT_LSB  = 29;
  localparam int HDR_BANK_LSB = 27;
  localparam int HDR_LEN_LSB  = 16;
  localparam int HDR_BASE_LSB = 0;

  // Highest legal bank index per target
  localparam logic [1:0] MAX_BANK_FV      = 2'd3;
  localparam logic [1:0] MAX_BANK_FV_INFO = 2'd0;
  localparam logic [1:0] MAX_BANK_NB_INFO = 2'd1;
  localparam logic [1:0] MAX_BANK_IMEM    = 2'd0;
  localparam logic [1:0] MAX_BANK_NB      = 2'd3;

  // A data-carrying header is legal when its target exists and the bank is in range.
  // Codes 5 and 6 are never legal; END is handled separately by the caller.
  function automatic logic hdr_legal(input logic [2:0] tgt, input logic [1:0] bank);
    logic ok;
    ok = 1'b0;
    case (tgt)
      TGT_FV:      ok = (bank <= MAX_BANK_FV);
      TGT_FV_INFO: ok = (bank <= MAX_BANK_FV_INFO);
      TGT_NB_INFO: ok = (bank <= MAX_BANK_NB_INFO);
      TGT_IMEM:    ok = (bank <= MAX_BANK_IMEM);
      TGT_NB:      ok = (bank <= MAX_BANK_NB);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sram_init_hdr_decode.sv
// Combinational header decoder: splits a header word into its fields and
// flags END markers and legal data-carrying headers.
module sram_init_hdr_decode
  import sram_init_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic [DATA_W-1:0] i_hdr,
  output logic [2:0]        o_tgt,
  output logic [1:0]        o_bank,
  output logic [LEN_W-1:0]  o_len_m1,
  output logic [ADDR_W-1:0] o_base,
  output logic              o_is_end,
  output logic              o_legal
);

  // Bits between the base and length fields carry no meaning
  logic w_unused_hdr;
  assign w_unused_hdr = ^i_hdr;

  assign o_tgt    = i_hdr[HDR_TGT_LSB +: 3];
  assign o_bank   = i_hdr[HDR_BANK_LSB +: 2];
  assign o_len_m1 = i_hdr[HDR_LEN_LSB +: LEN_W];
  assign o_base   = i_hdr[HDR_BASE_LSB +: ADDR_W];
  assign o_is_end = (o_tgt == TGT_END);
  assign o_legal  = hdr_legal(o_tgt, o_bank);

endmodule

// File: rtl/sram_init_loader.sv
// Turns a valid/ready stream of load packets into one-cycle SRAM write
// strobes, then raises init_done and pulses start_o on the END packet.
//
// Handshake: a word transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is registered; it is high in HDR and
// PAYLOAD and low in DONE and while/just after reset. The SRAM side has
// no backpressure: wr_valid is a pure one-cycle strobe per payload word.
module sram_init_loader
  import sram_init_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_valid,
  output logic [2:0]        wr_tgt,
  output logic [1:0]        wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              init_done,
  output logic              start_o,
  output logic              err,
  output logic [1:0]        dbg_state
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_in_ready;
  logic [2:0]          r_tgt;
  logic [1:0]          r_bank;
  logic [ADDR_W-1:0]   r_base;
  logic [LEN_W-1:0]    r_len_m1;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_drop;
  logic                r_wr_valid;
  logic [2:0]          r_wr_tgt;
  logic [1:0]          r_wr_bank;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_init_done;
  logic                r_start;
  logic                r_err;

  logic                w_accept;
  logic [2:0]          w_hdr_tgt;
  logic [1:0]          w_hdr_bank;
  logic [LEN_W-1:0]    w_hdr_len_m1;
  logic [ADDR_W-1:0]   w_hdr_base;
  logic                w_hdr_is_end;
  logic                w_hdr_legal;

  assign w_accept = in_valid & r_in_ready;

  sram_init_hdr_decode #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_hdr_decode (
    .i_hdr    (in_data),
    .o_tgt    (w_hdr_tgt),
    .o_bank   (w_hdr_bank),
    .o_len_m1 (w_hdr_len_m1),
    .o_base   (w_hdr_base),
    .o_is_end (w_hdr_is_end),
    .o_legal  (w_hdr_legal)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_HDR;
    else       r_state <= w_state_nxt;
  end

  // Next-state: header decides END vs payload; last payload word returns to HDR
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HDR:     if (w_accept) w_state_nxt = w_hdr_is_end ? ST_DONE : ST_PAYLOAD;
      ST_PAYLOAD: if (w_accept && (r_cnt == r_len_m1)) w_state_nxt = ST_HDR;
      ST_DONE:    w_state_nxt = ST_DONE;
      default:    w_state_nxt = ST_HDR;
    endcase
  end

  // Header latch, word counter, write register and sticky status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready  <= 1'b0;
      r_tgt       <= '0;
      r_bank      <= '0;
      r_base      <= '0;
      r_len_m1    <= '0;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_tgt    <= '0;
      r_wr_bank   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_init_done <= 1'b0;
      r_start     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != ST_DONE);
      r_wr_valid <= 1'b0;
      r_start    <= 1'b0;
      if ((r_state == ST_HDR) && w_accept) begin
        if (w_hdr_is_end) begin
          r_init_done <= 1'b1;
          r_start     <= 1'b1;
        end else begin
          // Illegal headers still latch length so their payload is skipped
          r_tgt    <= w_hdr_tgt;
          r_bank   <= w_hdr_bank;
          r_base   <= w_hdr_base;
          r_len_m1 <= w_hdr_len_m1;
          r_cnt    <= '0;
          r_drop   <= ~w_hdr_legal;
          if (!w_hdr_legal) r_err <= 1'b1;
        end
      end
      if ((r_state == ST_PAYLOAD) && w_accept) begin
        r_cnt      <= r_cnt + LEN_W'(1);
        r_wr_valid <= ~r_drop;
        if (!r_drop) begin
          r_wr_tgt  <= r_tgt;
          r_wr_bank <= r_bank;
          // Address wraps modulo 2^ADDR_W
          r_wr_addr <= r_base + ADDR_W'(r_cnt);
          r_wr_data <= in_data;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign wr_valid  = r_wr_valid;
  assign wr_tgt    = r_wr_tgt;
  assign wr_bank   = r_wr_bank;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign init_done = r_init_done;
  assign start_o   = r_start;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_init_loader.sv
// Bench for sram_init_loader: random packets, reference write list built from
// the header rules, observed writes time-stamped by a negedge monitor.
module tb_sram_init_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;
  // Scoreboard entry: {cycle, tgt, bank, addr, data}
  localparam int EW = 32 + 3 + 2 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              wr_valid;
  logic [2:0]        wr_tgt;
  logic [1:0]        wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              init_done;
  logic              start_o;
  logic              err;
  logic [1:0]        dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int max_bank[5] = '{3, 0, 1, 0, 3};

  sram_init_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .wr_valid  (wr_valid),
    .wr_tgt    (wr_tgt),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_done (init_done),
    .start_o   (start_o),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: capture every write strobe and count start pulses
  always @(negedge clk) begin
    if (wr_valid === 1'b1) obs_q.push_back({32'(cyc), wr_tgt, wr_bank, wr_addr, wr_data});
    if (start_o === 1'b1) start_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Driver: present one word, wait (bounded) for acceptance; acc = presentation cycle
  task automatic send_word(input logic [DATA_W-1:0] d, output int acc);
    int n;
    n = 0;
    acc = -1;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (in_ready === 1'b1) begin
      acc = cyc;
      @(posedge clk); #1;
    end else begin
      checks++; failures++;
      $display("FAIL handshake_timeout in_ready=%b required=1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  // Driver + reference model: one packet, legal payload words expected one cycle later
  task automatic send_packet(input logic [2:0] tgt, input logic [1:0] bank, input int len_m1,
                             input logic [ADDR_W-1:0] base, input int max_gap);
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] d;
    int acc;
    bit legal;
    hdr = {tgt, bank, 11'(len_m1), 6'($urandom_range(0, 63)), base};
    legal = 1'b0;
    if (tgt <= 3'd4) legal = (int'(bank) <= max_bank[tgt]);
    send_word(hdr, acc);
    for (int i = 0; i <= len_m1; i++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      d = $urandom;
      send_word(d, acc);
      if (legal && acc >= 0) exp_q.push_back({32'(acc + 1), tgt, bank, 10'(int'(base) + i), d});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    checks++;
    if ({in_ready, wr_valid, wr_tgt, wr_bank, wr_addr, wr_data, init_done, start_o, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b wv=%b tgt=%0d bank=%0d addr=%h data=%h done=%b start=%b err=%b required all 0",
               in_ready, wr_valid, wr_tgt, wr_bank, wr_addr, wr_data, init_done, start_o, err);
    end
    reset = 1'b0;
    idle(1);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_single;
    logic [EW-1:0] e, o;
    send_packet(3'd0, 2'd2, 3, 10'h010, 0);
    idle(3);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL single_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL single_wr got=%h required=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap;
    logic [EW-1:0] e, o;
    send_packet(3'd4, 2'd1, 2, 10'h3FE, 0);
    idle(3);
    checks++;
    if (obs_q.size() !== 3) begin failures++; $display("FAIL wrap_count got=%0d required=3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL wrap_wr got=%h required=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_illegal;
    logic [EW-1:0] e, o;
    send_packet(3'd2, 2'd3, 1, 10'($urandom), 0);
    send_packet(3'd5, 2'($urandom_range(0, 3)), 2, 10'($urandom), 0);
    idle(2);
    checks++;
    if (obs_q.size() !== 0) begin failures++; $display("FAIL illegal_no_write got=%0d required=0", obs_q.size()); end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b required=1", err); end
    send_packet(3'd3, 2'd0, 0, 10'($urandom), 0);
    idle(3);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL illegal_after_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL illegal_after_wr got=%h required=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_gapped;
    logic [EW-1:0] e, o;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] d;
    int acc;
    base = 10'($urandom);
    send_word({3'd0, 2'd1, 11'd2, 6'd0, base}, acc);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) idle(2);
      d = $urandom;
      send_word(d, acc);
      if (acc >= 0) exp_q.push_back({32'(acc + 1), 3'd0, 2'd1, 10'(int'(base) + i), d});
    end
    idle(3);
    checks++;
    if (obs_q.size() !== 3) begin failures++; $display("FAIL gapped_count got=%0d required=3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL gapped_wr got=%h required=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [EW-1:0] e, o;
    for (int p = 0; p < 12; p++)
      send_packet(3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), $urandom_range(0, 5),
                  10'($urandom), (p % 2 == 0) ? 0 : 2);
    idle(3);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL random_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL random_wr got=%h required=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [EW-1:0] e, o;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] d;
    int acc;
    base = 10'($urandom);
    send_word({3'd0, 2'd0, 11'd7, 6'd0, base}, acc);
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      send_word(d, acc);
      if (i == 0 && acc >= 0) exp_q.push_back({32'(acc + 1), 3'd0, 2'd0, base, d});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, wr_valid, wr_tgt, wr_bank, wr_addr, wr_data, init_done, start_o, err} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs ready=%b wv=%b tgt=%0d bank=%0d addr=%h data=%h done=%b start=%b err=%b required all 0",
               in_ready, wr_valid, wr_tgt, wr_bank, wr_addr, wr_data, init_done, start_o, err);
    end
    checks++;
    if (obs_q.size() !== 1) begin failures++; $display("FAIL reset_mid_count got=%0d required=1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_mid_wr got=%h required=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    idle(2);
    reset = 1'b0;
    // First word after release must be taken as a header for FV_info
    send_packet(3'd1, 2'd0, 0, 10'($urandom), 0);
    idle(3);
    checks++;
    if (obs_q.size() !== 1) begin failures++; $display("FAIL reset_mid_after_count got=%0d required=1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_mid_after_wr got=%h required=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_end;
    logic [EW-1:0] e, o;
    int acc;
    int s0;
    send_packet(3'd0, 2'd3, 1, 10'($urandom), 0);
    s0 = start_cnt;
    send_word(32'hE000_0000, acc);
    checks++;
    if ({start_o, init_done, in_ready} !== 3'b110) begin
      failures++;
      $display("FAIL end_first_cycle start=%b done=%b ready=%b required 1 1 0", start_o, init_done, in_ready);
    end
    idle(1);
    checks++;
    if ({start_o, init_done} !== 2'b01) begin
      failures++;
      $display("FAIL end_second_cycle start=%b done=%b required 0 1", start_o, init_done);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin in_data = $urandom; idle(1); end
    in_valid = 1'b0;
    idle(2);
    checks++;
    if ({init_done, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL end_sticky done=%b ready=%b required 1 0", init_done, in_ready);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin failures++; $display("FAIL end_start_pulses got=%0d required=1", start_cnt - s0); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL end_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL end_wr got=%h required=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_illegal();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    test_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
